bcd_counter_chain: RTL and testbench
====================================

BCD_COUNTER_CHAIN -- requirements
Module: bcd_counter_chain

Interface
REQ-001 The module SHALL have parameter DIGITS, default 2, meaning the number of cascaded BCD digits (1..8).
REQ-002 The module SHALL have parameter TOP_MOD, default 6, meaning the modulus of the most-significant digit (2..10); all other digits are modulo 10.
REQ-003 The module SHALL have port CP, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port CR, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port CTP, input, 1 bit: count enable (parallel).
REQ-006 The module SHALL have port CTT, input, 1 bit: count enable (trickle); also gates CO.
REQ-007 The module SHALL have port UP, input, 1 bit: direction, 1 = up, 0 = down.
REQ-008 The module SHALL have port SCLR, input, 1 bit: synchronous clear, active-high.
REQ-009 The module SHALL have port LD, input, 1 bit: synchronous parallel load, active-high.
REQ-010 The module SHALL have port D, input, 4*DIGITS bits: load value, digit 0 in D[3:0].
REQ-011 The module SHALL have port Q, output, 4*DIGITS bits: registered count, digit 0 in Q[3:0].
REQ-012 The module SHALL have port CO, output, 1 bit: combinational carry/borrow out for cascading.
REQ-013 The module SHALL have port TICK, output, 1 bit: registered one-cycle wrap pulse.
REQ-014 The module SHALL have port LDERR, output, 1 bit: registered one-cycle invalid-load flag.

Function
REQ-015 Update priority per edge SHALL be: SCLR, then LD, then count; count occurs only when CTP=1 and CTT=1.
REQ-016 SCLR=1 SHALL set Q to all zero and TICK=0, LDERR=0, regardless of LD/CTP/CTT.
REQ-017 LD=1 SHALL load D digit-wise; any digit >9 (or >=TOP_MOD for the top digit) SHALL load as 0, and LDERR SHALL be 1 for the next cycle only.
REQ-018 Counting up, digit k SHALL increment when all lower digits equal their maximum; a digit at its maximum SHALL wrap to 0.
REQ-019 Counting down, digit k SHALL decrement when all lower digits equal 0; a digit at 0 SHALL wrap to its maximum (9, or TOP_MOD-1 for the top digit).
REQ-020 Terminal count SHALL be all digits at maximum (UP=1) or all digits 0 (UP=0).
REQ-021 CO SHALL equal terminal count AND CTT, combinationally, independent of CTP, so that chains ripple like a 74LS161 carry.
REQ-022 TICK SHALL be 1 in the cycle after an edge on which a counting step wrapped the full chain (terminal count with CTP=CTT=1), else 0.
REQ-023 Changing UP with enables held SHALL take effect on the next edge with no lost or duplicated step.
REQ-024 Count sequence length SHALL be TOP_MOD*10^(DIGITS-1); e.g. defaults give 00..59.
REQ-025 Holding (CTP=0 or CTT=0, no SCLR/LD) SHALL keep Q, and TICK=LDERR=0.

Reset
REQ-026 CR=0 SHALL immediately force Q=0, TICK=0, LDERR=0, regardless of CP.
REQ-027 Release of CR SHALL not itself cause a count; first count occurs on the first rising CP edge with CR=1 and enables high.
REQ-028 CR asserted mid-sequence or during LD SHALL abort that operation with no residual pulse after release.

Structure
REQ-029 A shared package SHALL hold the digit width constant (4), BCD maximum (9), and parameter legality limits.
REQ-030 One sub-module, bcd_digit (parameter MOD; carry-in enable, direction, load value; count and terminal outputs), SHALL be instantiated DIGITS times via generate.
REQ-031 Illegal DIGITS or TOP_MOD SHALL be rejected at elaboration.

Verification
REQ-032 Defaults, CR pulse then CTP=CTT=UP=1 for 60 edges -> Q steps 00..59, returns to 00; TICK=1 exactly once, the cycle after 59->00.
REQ-033 Q=59, UP=1, CTT=1, CTP=0 -> CO=1, Q stays 59; CTT=0 -> CO=0.
REQ-034 Load D=0x40, UP=0, count 41 edges -> Q 40,39..00,59; CO=1 while Q=00 with CTT=1.
REQ-035 LD with D=0x7A -> Q=00 next edge (both digits invalid), LDERR=1 for one cycle; LD with D=0x59 -> Q=59, LDERR=0.
REQ-036 SCLR=1 and LD=1 together at Q=23 -> Q=00; CR=0 asynchronously at Q=37 between edges -> Q=00 before next edge.
REQ-037 DIGITS=3, TOP_MOD=10: count up from 998 -> 999 (CO=1), 000 with TICK=1 next cycle.

Source files
------------

// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants and helpers for the cascaded BCD counter chain.
// Holds the digit width, the BCD maximum and the legal parameter ranges.
package bcd_counter_chain_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;

  localparam int DIGITS_MIN  = 1;
  localparam int DIGITS_MAX  = 8;
  localparam int TOP_MOD_MIN = 2;
  localparam int TOP_MOD_MAX = 10;

  // Largest value a digit of the given modulus can hold.
  function automatic digit_t digit_max(input int modulus);
    return digit_t'(modulus - 1);
  endfunction

  function automatic bit params_legal(input int digits, input int top_mod);
    return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX) &&
           (top_mod >= TOP_MOD_MIN) && (top_mod <= TOP_MOD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// One BCD digit of the chain: modulo-MOD up/down counter with clear and load.
// term is the combinational terminal flag for the current direction.
module bcd_digit
  import bcd_counter_chain_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sclr,
  input  logic   ld,
  input  digit_t ld_val,
  input  logic   cnt_en,
  input  logic   up,
  output digit_t q,
  output logic   term,
  output logic   ld_bad
);

  localparam digit_t MAXV = digit_max(MOD);

  if ((MOD < TOP_MOD_MIN) || (MOD > TOP_MOD_MAX)) begin : g_bad_mod
    $error("bcd_digit: MOD out of range");
  end

  digit_t q_q;
  digit_t q_d;

  assign ld_bad = (ld_val > MAXV);
  assign term   = up ? (q_q == MAXV) : (q_q == '0);
  assign q      = q_q;

  // term doubles as the wrap condition for the current direction.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = ld_bad ? '0 : ld_val;
    end else if (cnt_en) begin
      if (up) begin
        q_d = term ? '0 : q_q + 4'd1;
      end else begin
        q_d = term ? MAXV : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded BCD up/down counter with 74LS161-style CTP/CTT enables,
// synchronous clear/load, ripple carry out and registered wrap/load-error pulses.
module bcd_counter_chain
  import bcd_counter_chain_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int TOP_MOD = 6
) (
  input  logic                    CP,
  input  logic                    CR,
  input  logic                    CTP,
  input  logic                    CTT,
  input  logic                    UP,
  input  logic                    SCLR,
  input  logic                    LD,
  input  logic [4*DIGITS-1:0]     D,
  output logic [4*DIGITS-1:0]     Q,
  output logic                    CO,
  output logic                    TICK,
  output logic                    LDERR
);

  if (!params_legal(DIGITS, TOP_MOD)) begin : g_bad_params
    $error("bcd_counter_chain: DIGITS or TOP_MOD out of range");
  end

  logic [DIGITS-1:0] term_vec;
  logic [DIGITS-1:0] bad_vec;
  logic [DIGITS-1:0] cnt_en;
  logic              chain_run;
  logic              chain_wrap;
  logic              tick_q, tick_d;
  logic              lderr_q, lderr_d;

  // Digit k steps only when every lower digit is at its terminal value.
  always_comb begin
    chain_run = CTP & CTT;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_en[i] = chain_run;
      chain_run = chain_run & term_vec[i];
    end
    chain_wrap = chain_run;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    localparam int MOD = (k == DIGITS - 1) ? TOP_MOD : int'(BCD_MAX) + 1;

    bcd_digit #(
      .MOD(MOD)
    ) u_digit (
      .clk   (CP),
      .rst_n (CR),
      .sclr  (SCLR),
      .ld    (LD),
      .ld_val(D[k*DIGIT_W +: DIGIT_W]),
      .cnt_en(cnt_en[k]),
      .up    (UP),
      .q     (Q[k*DIGIT_W +: DIGIT_W]),
      .term  (term_vec[k]),
      .ld_bad(bad_vec[k])
    );
  end

  // Carry out ignores CTP so that cascaded chains ripple on CTT alone.
  assign CO = (&term_vec) & CTT;

  always_comb begin
    tick_d  = 1'b0;
    lderr_d = 1'b0;
    if (!SCLR) begin
      if (LD) begin
        lderr_d = |bad_vec;
      end else begin
        tick_d = chain_wrap;
      end
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      tick_q  <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      lderr_q <= lderr_d;
    end
  end

  assign TICK  = tick_q;
  assign LDERR = lderr_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench for bcd_counter_chain: an integer-count model checked every
// cycle, directed scenarios with literal expectations, and randomized stimulus.
module tb_bcd_counter_chain;

  localparam int TOP   = 6;
  localparam int N_SEQ = TOP * 10;

  logic       CP = 1'b0;
  logic       CR = 1'b0;
  logic       CTP = 1'b0, CTT = 1'b0, UP = 1'b1, SCLR = 1'b0, LD = 1'b0;
  logic [7:0] D = '0;
  logic [7:0] Q;
  logic       CO, TICK, LDERR;

  logic        CTP2 = 1'b0, CTT2 = 1'b0, UP2 = 1'b1, SCLR2 = 1'b0, LD2 = 1'b0;
  logic [11:0] D2 = '0;
  logic [11:0] Q2;
  logic        CO2, TICK2, LDERR2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int m_cnt   = 0;
  bit m_tick  = 1'b0;
  bit m_lderr = 1'b0;

  bcd_counter_chain #(.DIGITS(2), .TOP_MOD(TOP)) dut (
    .CP(CP), .CR(CR), .CTP(CTP), .CTT(CTT), .UP(UP), .SCLR(SCLR), .LD(LD),
    .D(D), .Q(Q), .CO(CO), .TICK(TICK), .LDERR(LDERR)
  );

  bcd_counter_chain #(.DIGITS(3), .TOP_MOD(10)) dut3 (
    .CP(CP), .CR(CR), .CTP(CTP2), .CTT(CTT2), .UP(UP2), .SCLR(SCLR2), .LD(LD2),
    .D(D2), .Q(Q2), .CO(CO2), .TICK(TICK2), .LDERR(LDERR2)
  );

  // ---------------- clock ----------------
  always #5 CP = ~CP;

  // ---------------- helpers ----------------
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ctl(input logic ctp, input logic ctt, input logic up,
                         input logic sclr, input logic ld, input logic [7:0] d);
    #1;
    CTP = ctp; CTT = ctt; UP = up; SCLR = sclr; LD = ld; D = d;
  endtask

  task automatic step();
    @(negedge CP);
  endtask

  // ---------------- behavioural model (count as a plain integer 0..59) ----------------
  always @(posedge CP or negedge CR) begin
    int t;
    int o;
    bit bad;
    if (!CR) begin
      m_cnt = 0; m_tick = 1'b0; m_lderr = 1'b0;
    end else begin
      m_tick  = 1'b0;
      m_lderr = 1'b0;
      if (SCLR) begin
        m_cnt = 0;
      end else if (LD) begin
        t = int'(D[7:4]);
        o = int'(D[3:0]);
        bad = 1'b0;
        if (t >= TOP) begin t = 0; bad = 1'b1; end
        if (o > 9)    begin o = 0; bad = 1'b1; end
        m_cnt   = t * 10 + o;
        m_lderr = bad;
      end else if (CTP && CTT) begin
        if (UP) begin
          m_tick = (m_cnt == N_SEQ - 1);
          m_cnt  = (m_cnt + 1) % N_SEQ;
        end else begin
          m_tick = (m_cnt == 0);
          m_cnt  = (m_cnt + N_SEQ - 1) % N_SEQ;
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge CP) begin
    bit tc;
    if (chk_en) begin
      tc = UP ? (m_cnt == N_SEQ - 1) : (m_cnt == 0);
      check("model_q", {24'd0, Q}, {24'd0, to_bcd(m_cnt)});
      check("model_tick", {31'd0, TICK}, {31'd0, m_tick});
      check("model_lderr", {31'd0, LDERR}, {31'd0, m_lderr});
      check("model_co", {31'd0, CO}, {31'd0, tc & CTT});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int tick_cnt;
    logic up_r;
    logic [7:0] d_r;

    repeat (2) step();
    check("reset_q", {24'd0, Q}, 32'h0);
    check("reset_tick", {31'd0, TICK}, 32'h0);
    check("reset_lderr", {31'd0, LDERR}, 32'h0);
    #1 CR = 1'b1;
    chk_en = 1'b1;

    // Full up sequence 00..59 and back to 00
    set_ctl(1, 1, 1, 0, 0, 8'h00);
    tick_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (TICK) tick_cnt++;
      if (i == 0)  check("up_first", {24'd0, Q}, 32'h01);
      if (i == 58) check("up_59", {24'd0, Q}, 32'h59);
    end
    check("up_wrap_q", {24'd0, Q}, 32'h00);
    check("up_tick_once", tick_cnt, 1);

    // Carry out at 59 with CTP low
    set_ctl(0, 0, 1, 0, 1, 8'h59);
    step();
    set_ctl(0, 1, 1, 0, 0, 8'h00);
    step();
    check("hold_q59", {24'd0, Q}, 32'h59);
    check("co_ctt1", {31'd0, CO}, 32'h1);
    set_ctl(0, 0, 1, 0, 0, 8'h00);
    #1 check("co_ctt0", {31'd0, CO}, 32'h0);

    // Down count from 40 through 00 to 59
    step();
    set_ctl(0, 0, 0, 0, 1, 8'h40);
    step();
    check("load_40", {24'd0, Q}, 32'h40);
    set_ctl(1, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 41; i++) begin
      step();
      if (Q == 8'h00) check("down_co_at_00", {31'd0, CO}, 32'h1);
    end
    check("down_end_59", {24'd0, Q}, 32'h59);
    check("down_wrap_tick", {31'd0, TICK}, 32'h1);

    // Invalid and valid loads
    set_ctl(0, 0, 1, 0, 1, 8'h7A);
    step();
    check("bad_load_q", {24'd0, Q}, 32'h00);
    check("bad_load_err", {31'd0, LDERR}, 32'h1);
    set_ctl(0, 0, 1, 0, 1, 8'h59);
    step();
    check("good_load_q", {24'd0, Q}, 32'h59);
    check("good_load_err", {31'd0, LDERR}, 32'h0);

    // SCLR beats LD
    set_ctl(0, 0, 1, 0, 1, 8'h23);
    step();
    set_ctl(1, 1, 1, 1, 1, 8'h45);
    step();
    check("sclr_over_ld", {24'd0, Q}, 32'h00);

    // Asynchronous reset between edges
    set_ctl(0, 0, 1, 0, 1, 8'h37);
    step();
    check("load_37", {24'd0, Q}, 32'h37);
    set_ctl(1, 1, 1, 0, 0, 8'h00);
    #1 CR = 1'b0;
    #1 check("async_cr_q", {24'd0, Q}, 32'h00);
    #1 CR = 1'b1;
    step();
    check("after_cr_count", {24'd0, Q}, 32'h01);

    // Reset held across an invalid load leaves no LDERR pulse
    set_ctl(0, 0, 1, 0, 1, 8'h7A);
    #1 CR = 1'b0;
    step();
    check("cr_ld_abort_err", {31'd0, LDERR}, 32'h0);
    set_ctl(0, 0, 1, 0, 0, 8'h00);
    #1 CR = 1'b1;
    step();
    check("cr_ld_no_residual", {31'd0, LDERR}, 32'h0);

    // Randomized traffic with direction changes and occasional async resets
    up_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) up_r = ~up_r;
      d_r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                        : to_bcd($urandom_range(0, N_SEQ - 1));
      set_ctl($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, up_r,
              $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0, d_r);
      if ($urandom_range(0, 49) == 0) begin
        #1 CR = 1'b0;
        #1 check("rand_async_cr", {24'd0, Q}, 32'h00);
        #1 CR = 1'b1;
      end
      step();
    end

    // Three-digit decade chain wrapping 999 -> 000 and back
    set_ctl(0, 0, 1, 0, 0, 8'h00);
    #0;
    LD2 = 1'b1; D2 = 12'h998; UP2 = 1'b1;
    step();
    check("d3_load", {20'd0, Q2}, 32'h998);
    #1;
    LD2 = 1'b0; CTP2 = 1'b1; CTT2 = 1'b1;
    step();
    check("d3_999", {20'd0, Q2}, 32'h999);
    check("d3_co", {31'd0, CO2}, 32'h1);
    check("d3_no_tick", {31'd0, TICK2}, 32'h0);
    step();
    check("d3_000", {20'd0, Q2}, 32'h000);
    check("d3_tick", {31'd0, TICK2}, 32'h1);
    #1 UP2 = 1'b0;
    step();
    check("d3_down_999", {20'd0, Q2}, 32'h999);
    check("d3_down_tick", {31'd0, TICK2}, 32'h1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
